// File: rtl/lc3_io_pkg.sv
// Shared LC3 memory-mapped I/O definitions: device addresses and status-bit
// positions for the keyboard and display registers.
package lc3_io_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int KBSR_READY = 15;
  localparam int KBSR_IE    = 14;
  localparam int KBSR_OVR   = 13;
  localparam int DSR_READY  = 15;

  function automatic logic [15:0] kbsr_word(input logic ready, input logic ie,
                                            input logic ovr);
    logic [15:0] w;
    w = '0;
    w[KBSR_READY] = ready;
    w[KBSR_IE]    = ie;
    w[KBSR_OVR]   = ovr;
    return w;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces an active-low push-button; emits a one-cycle
// press pulse on each accepted released->pressed transition.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       prime_q, prime_d;
  logic             armed_q, armed_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // A key held through reset must be seen released before it can report a
  // press; prime_q waits until the synchronizer holds real samples.
  always_comb begin
    sync_d   = {sync_q[0], key_n};
    prime_d  = {prime_q[0], 1'b1};
    armed_d  = armed_q | (prime_q[1] & sync_q[1]);
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        press_d  = stable_q & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      prime_q  <= 2'b00;
      armed_q  <= 1'b0;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prime_q  <= prime_d;
      armed_q  <= armed_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/lc3_kbd_io.sv
// LC3 keyboard device: KBSR/KBDR bus responder fed by a debounced push-button
// that latches the slide switches on each press.
module lc3_kbd_io
  import lc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  input  logic        mem_en,
  input  logic        mem_w,
  output logic        sel,
  output logic [15:0] rdata,
  input  logic [9:0]  switches,
  input  logic        key_n,
  output logic        irq,
  output logic        ready_led
);

  logic        kb_press;
  logic        hit_kbsr, hit_kbdr;
  logic        rd_kbsr, rd_kbdr, wr_kbsr;
  logic [9:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ie_q, ie_d;
  logic        ovr_q, ovr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        unused_mdr;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_debouncer (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_n),
    .press  (kb_press)
  );

  assign hit_kbsr = (mar == KBSR_ADDR);
  assign hit_kbdr = (mar == KBDR_ADDR);
  assign sel      = hit_kbsr | hit_kbdr;
  assign rd_kbsr  = mem_en & ~mem_w & hit_kbsr;
  assign rd_kbdr  = mem_en & ~mem_w & hit_kbdr;
  assign wr_kbsr  = mem_en &  mem_w & hit_kbsr;

  assign unused_mdr = ^{mdr_in[15], mdr_in[13:0]};

  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    ie_d    = ie_q;
    ovr_d   = ovr_q;
    rdata_d = 16'h0000;
    if (rd_kbsr) rdata_d = kbsr_word(ready_q, ie_q, ovr_q);
    if (rd_kbdr) begin
      rdata_d = {6'b0, data_q};
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (wr_kbsr) ie_d = mdr_in[KBSR_IE];
    // A press colliding with a KBDR read counts as consumed, not overrun.
    if (kb_press) begin
      data_d  = switches;
      ready_d = 1'b1;
      ovr_d   = ovr_d | (ready_q & ~rd_kbdr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      ready_q <= 1'b0;
      ie_q    <= 1'b0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
      ie_q    <= ie_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = ready_q & ie_q;
  assign ready_led = ready_q;

endmodule

// File: doc/lc3_kbd_io.md
# lc3_kbd_io

Memory-mapped keyboard input device for the LC3 CPU: the responder side of the CPU's memory bus for the KBSR/KBDR registers. It debounces the board push-button `key[1]` and, on each clean press, latches the slide `switches` into KBDR and raises the KBSR ready flag. The CPU polls KBSR and reads KBDR through the same MAR/MEM_EN/MEM_W bus it uses for RAM. The memory controller muxes this block's read data in place of RAM whenever `sel` is high.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required to accept a key level change (sim-friendly; board build uses 500000).
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset (board `key[0]`).
- `mar` in 16: bus address.
- `mdr_in` in 16: CPU write data.
- `mem_en` in 1: bus access strobe, one cycle per access.
- `mem_w` in 1: 1 = write, 0 = read; qualified by `mem_en`.
- `sel` out 1: combinational; 1 when `mar` is KBSR (16'hFE00) or KBDR (16'hFE02).
- `rdata` out 16: registered read data.
- `switches` in 10: raw slide switches; sampled only on an accepted press.
- `key_n` in 1: raw `key[1]`, active-low, asynchronous to `clk`.
- `irq` out 1: `kbsr_ready & kbsr_ie`.
- `ready_led` out 1: mirrors `kbsr_ready` for LEDG.

## Operation
- Input path: 2-flop synchronizer on `key_n`, then the debouncer.
  - Debouncer holds a stable level; the counter resets whenever the synced input equals the stable level.
  - When the input has differed from the stable level for DEBOUNCE_CYCLES consecutive cycles, the stable level flips.
  - A press event is a stable 1->0 transition. It lasts one cycle and fires only once per press.
- Press event:
  - KBDR <= {6'b0, switches}.
  - `kbsr_ready` <= 1.
  - If `kbsr_ready` was already 1, `kbsr_ovr` <= 1. The data is still overwritten with the newest value.
- Register map:
  - KBSR = {ready, ie, ovr, 13'b0}.
  - KBDR = {6'b0, data[9:0]}.
- Reads (`mem_en & ~mem_w & sel`):
  - `rdata` <= addressed register, sampled before this edge's updates.
  - Reading KBDR clears `kbsr_ready` and `kbsr_ovr`.
  - Reading KBSR has no side effect.
- Reads with `sel` = 0, or no access: `rdata` <= 16'h0000.
- Writes (`mem_en & mem_w & sel`):
  - KBSR write updates `ie` <= mdr_in[14] only. `ready` and `ovr` are read-only.
  - KBDR writes are ignored.
- Simultaneous KBDR read and press event in the same cycle:
  - The read returns the old data.
  - The press wins: `ready` stays 1 and the new data is latched.
  - `ovr` ends at 0, because the read consumed the old value.
- Unmapped addresses (anything other than FE00/FE02): `sel` = 0 and no state change.

## Timing
- Reset values: `rdata` = 0, KBDR = 0, `ready` = 0, `ie` = 0, `ovr` = 0, `irq` = 0, `ready_led` = 0.
  - Debouncer stable level = 1 (released); counter = 0; synchronizer flops = 1.
- Reset asserted mid-debounce or mid-access: all state returns to reset values immediately. No press is reported for a key held through reset until it is released and pressed again.
- Press latency: `key_n` falling at edge N gives `ready` = 1 after edge N + 2 + DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Read latency: one cycle. Access at edge N gives `rdata` valid after edge N until edge N+1.
- `ready` clears at the same edge that captures the KBDR read.
- `irq` and `ready_led` are combinational from registers and glitch-free.
- `sel` is purely combinational on `mar`.

## Structure
- Shared package `lc3_io_pkg`:
  - `KBSR_ADDR` = 16'hFE00, `KBDR_ADDR` = 16'hFE02.
  - Bit indices `KBSR_READY` = 15, `KBSR_IE` = 14, `KBSR_OVR` = 13.
  - The display-side DSR/DDR constants go in the same package.
- One sub-module: `key_debouncer`, containing the synchronizer, counter, stable level and one-cycle `press` pulse output. It is reused for `key[2]`/`key[3]` later.
- `lc3_kbd_io` contains the register file, address decode and read mux.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles, then release. Read FE00 -> `rdata` = 16'h0000 one cycle later; `irq` = 0.
- Clean press: `switches` = 10'h2A5, `key_n` low for 40 cycles.
  - `ready` = 1 exactly 18 cycles after the falling edge.
  - Read FE00 -> 16'h8000; read FE02 -> 16'h02A5.
  - Next FE00 read -> 16'h0000.
- Glitch: `key_n` low for 10 cycles (< 16) -> no event; KBSR stays 16'h0000.
- Overrun: two presses with `switches` 10'h001 then 10'h002, no read between.
  - FE00 reads 16'hA000; FE02 reads 16'h0002.
  - FE00 then reads 16'h0000.
- Interrupt enable: write FE00 with 16'h4000, then press.
  - `irq` goes 1 with `ready`; FE00 reads 16'hC000.
  - KBDR read drops `irq`.
  - Write FE02 and write FE00 with 16'h8000 -> no change to data or `ready`; `ie` clears.
- Collision: time a KBDR read on the press-event cycle.
  - Read returns the old data; `ready` stays 1; `ovr` = 0.
  - Next FE02 read returns the new switches value.
